// File: rtl/fir_fifo_uart_streamer.sv
// Drains the FIR output FIFO one word at a time and ships each word over 8N1 UART
// as a SYNC_BYTE followed by the sample bytes, most significant byte first.
module fir_fifo_uart_streamer #(
    parameter int         DATA_WIDTH   = 32,
    parameter int         CLKS_PER_BIT = 104,
    parameter logic [7:0] SYNC_BYTE    = 8'hA5
) (
    input  logic                  i_clk,
    input  logic                  i_rstn,
    input  logic                  i_enable,
    input  logic                  i_fifo_empty,
    input  logic [DATA_WIDTH-1:0] i_fifo_rddata,
    output logic                  o_fifo_rden,
    output logic                  o_uart_tx,
    output logic                  o_busy,
    output logic                  o_frame_done
);
    localparam int NBYTES = DATA_WIDTH / 8;
    localparam int BAUD_W = $clog2(CLKS_PER_BIT);
    localparam int IDX_W  = $clog2(NBYTES + 1);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_POP   = 3'd1;
    localparam logic [2:0] S_LATCH = 3'd2;
    localparam logic [2:0] S_START = 3'd3;
    localparam logic [2:0] S_DATA  = 3'd4;
    localparam logic [2:0] S_STOP  = 3'd5;

    logic [2:0]            state;
    logic [BAUD_W-1:0]     baud_cnt;
    logic [2:0]            bit_cnt;
    logic [IDX_W-1:0]      byte_idx;
    logic [7:0]            shifter;
    logic [DATA_WIDTH-1:0] sample;
    logic                  frame_end;
    logic                  baud_last;
    logic                  start_frame;
    logic                  on_line;

    assign baud_last   = (baud_cnt == BAUD_W'(CLKS_PER_BIT - 1));
    assign start_frame = i_enable && !i_fifo_empty;
    assign on_line     = (state == S_START) || (state == S_DATA) || (state == S_STOP);

    // The line is registered from the state, so it trails the FSM by one cycle;
    // frame_done is delayed through frame_end to line up with the real end of the stop bit.
    always_ff @(posedge i_clk) begin
        if (!i_rstn) begin
            state        <= S_IDLE;
            baud_cnt     <= '0;
            bit_cnt      <= '0;
            byte_idx     <= '0;
            shifter      <= '0;
            sample       <= '0;
            frame_end    <= 1'b0;
            o_fifo_rden  <= 1'b0;
            o_uart_tx    <= 1'b1;
            o_busy       <= 1'b0;
            o_frame_done <= 1'b0;
        end else begin
            o_fifo_rden  <= 1'b0;
            frame_end    <= 1'b0;
            o_frame_done <= frame_end;
            o_busy       <= (state != S_IDLE) || start_frame;
            baud_cnt     <= (on_line && !baud_last) ? baud_cnt + 1'b1 : '0;
            case (state)
                S_IDLE: begin
                    o_uart_tx <= 1'b1;
                    if (start_frame) begin
                        o_fifo_rden <= 1'b1;
                        state       <= S_POP;
                    end
                end
                S_POP: begin
                    o_uart_tx <= 1'b1;
                    state     <= S_LATCH;
                end
                S_LATCH: begin
                    o_uart_tx <= 1'b1;
                    sample    <= i_fifo_rddata;
                    shifter   <= SYNC_BYTE;
                    byte_idx  <= '0;
                    state     <= S_START;
                end
                S_START: begin
                    o_uart_tx <= 1'b0;
                    if (baud_last) begin
                        bit_cnt <= '0;
                        state   <= S_DATA;
                    end
                end
                S_DATA: begin
                    o_uart_tx <= shifter[0];
                    if (baud_last) begin
                        shifter <= {1'b0, shifter[7:1]};
                        bit_cnt <= bit_cnt + 1'b1;
                        if (bit_cnt == 3'd7) state <= S_STOP;
                    end
                end
                S_STOP: begin
                    o_uart_tx <= 1'b1;
                    if (baud_last) begin
                        if (byte_idx < IDX_W'(NBYTES)) begin
                            // sample shifts up so its top byte is always the next one out
                            shifter  <= sample[DATA_WIDTH-1 -: 8];
                            sample   <= sample << 8;
                            byte_idx <= byte_idx + 1'b1;
                            state    <= S_START;
                        end else begin
                            frame_end <= 1'b1;
                            state     <= S_IDLE;
                        end
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end
endmodule
